// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner FSM encoding plus key-code and one-hot/index helpers.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, CONFIRM, HELD} state_t;

    localparam int VEC_W = 32;

    function automatic int oh_to_idx(input logic [VEC_W-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < VEC_W; i++)
            if (oh[i]) idx = i;
        return idx;
    endfunction

    function automatic logic [VEC_W-1:0] idx_to_oh(input int idx);
        return VEC_W'(1) << idx;
    endfunction

    function automatic int code_of(input logic [VEC_W-1:0] row_oh, input int col_idx, input int num_cols);
        return oh_to_idx(row_oh) * num_cols + col_idx;
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: circular event buffer; head is read from registered storage, no fall-through.
module keypad_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign valid   = wr_ptr != rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign rdata   = valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes columns, synchronises and debounces rows, locks one key
// and queues press/release events into a small FIFO.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 4,
    parameter int SCAN_DIV       = 32,
    parameter int DEBOUNCE_LEN   = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPORT_RELEASE = 1,
    localparam int CODE_W        = $clog2(NUM_ROWS * NUM_COLS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] cols,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CODE_W-1:0]   evt_code,
    output logic                evt_release,
    output logic                key_held,
    output logic [CODE_W-1:0]   held_code,
    output logic                multi_key,
    output logic                overflow,
    input  logic                ovf_clr
);
    localparam int DW_W  = $clog2(SCAN_DIV);
    localparam int CI_W  = $clog2(NUM_COLS);
    localparam int CNT_W = $clog2(DEBOUNCE_LEN + 2);

    state_t state;
    logic [NUM_ROWS-1:0] rs_meta, rs, row_oh;
    logic [DW_W-1:0] dwell;
    logic [CI_W-1:0] col_idx, col_nxt;
    logic [NUM_COLS-1:0] cols_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CODE_W-1:0] code, push_code;
    logic [CODE_W:0] head;
    logic sample, cnt_done, extra, extra_seen, push, push_rel, fifo_full, drop;

    assign sample   = dwell == DW_W'(SCAN_DIV - 1);
    assign col_nxt  = col_idx == CI_W'(NUM_COLS - 1) ? '0 : col_idx + CI_W'(1);
    assign cols_nxt = NUM_COLS'(idx_to_oh(int'(col_nxt)));
    assign cnt_done = cnt + CNT_W'(1) >= CNT_W'(DEBOUNCE_LEN);
    assign code     = CODE_W'(code_of(VEC_W'(row_oh), int'(col_idx), NUM_COLS));
    assign extra    = |(rs & ~row_oh);
    assign drop     = push && fifo_full && !(evt_valid && evt_ready);
    assign {evt_release, evt_code} = head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) {rs, rs_meta} <= '0;
        else {rs, rs_meta} <= {rs_meta, rows};
    end

    // Column and dwell only move in SCAN; CONFIRM/HELD keep the locked column driven.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SCAN;
            dwell      <= '0;
            col_idx    <= '0;
            cols       <= NUM_COLS'(1);
            row_oh     <= '0;
            cnt        <= '0;
            extra_seen <= 1'b0;
            key_held   <= 1'b0;
            held_code  <= '0;
            multi_key  <= 1'b0;
            push       <= 1'b0;
            push_rel   <= 1'b0;
            push_code  <= '0;
        end else begin
            multi_key <= 1'b0;
            push      <= 1'b0;
            case (state)
                SCAN: begin
                    dwell <= sample ? '0 : dwell + DW_W'(1);
                    if (sample && $onehot(rs)) begin
                        row_oh <= rs;
                        cnt    <= CNT_W'(1);
                        state  <= CONFIRM;
                    end else if (sample) begin
                        multi_key <= |rs;
                        col_idx   <= col_nxt;
                        cols      <= cols_nxt;
                    end
                end
                CONFIRM: begin
                    cnt <= cnt + CNT_W'(1);
                    if (rs != row_oh) begin
                        state   <= SCAN;
                        col_idx <= col_nxt;
                        cols    <= cols_nxt;
                    end else if (cnt_done) begin
                        push       <= 1'b1;
                        push_rel   <= 1'b0;
                        push_code  <= code;
                        key_held   <= 1'b1;
                        held_code  <= code;
                        cnt        <= '0;
                        extra_seen <= 1'b0;
                        state      <= HELD;
                    end
                end
                HELD: begin
                    extra_seen <= extra;
                    multi_key  <= extra && !extra_seen;
                    cnt        <= rs == '0 ? cnt + CNT_W'(1) : '0;
                    if (rs == '0 && cnt_done) begin
                        key_held  <= 1'b0;
                        push      <= REPORT_RELEASE != 0;
                        push_rel  <= 1'b1;
                        push_code <= held_code;
                        cnt       <= '0;
                        state     <= SCAN;
                        col_idx   <= col_nxt;
                        cols      <= cols_nxt;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) overflow <= 1'b0;
        else overflow <= drop || (overflow && !ovf_clr);
    end

    keypad_evt_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(CODE_W + 1)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .wdata({push_rel, push_code}),
        .pop  (evt_ready),
        .rdata(head),
        .valid(evt_valid),
        .full (fifo_full)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan, debounce, chord detection and event FIFO behaviour.
module tb_keypad_scanner;

    logic clk = 1'b0;
    logic reset, evt_ready, ovf_clr;
    logic [3:0] rows, cols, evt_code, held_code, glitch, mk_cols;
    logic evt_valid, evt_release, key_held, multi_key, overflow;
    logic [15:0] keys;
    logic [4:0] ev_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int mk_n;

    always #5 clk = ~clk;

    // Matrix model: a pressed key connects its row to its column strobe.
    always_comb
        for (int r = 0; r < 4; r++) rows[r] = (|(keys[r*4 +: 4] & cols)) | glitch[r];

    always @(negedge clk)
        if (!reset && evt_valid && evt_ready) ev_q.push_back({evt_release, evt_code});

    keypad_scanner #(
        .NUM_ROWS(4), .NUM_COLS(4), .SCAN_DIV(4), .DEBOUNCE_LEN(4),
        .FIFO_DEPTH(4), .REPORT_RELEASE(1)
    ) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_release(evt_release), .key_held(key_held), .held_code(held_code),
        .multi_key(multi_key), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_held(input string tag, input logic v);
        int n = 0;
        while (key_held !== v && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(key_held), 32'(v));
    endtask

    task automatic expect_ev(input string tag, input logic rel, input logic [3:0] code);
        logic [31:0] got;
        if (ev_q.size() != 0) got = 32'(ev_q.pop_front());
        else got = 32'hffff_ffff;
        check(tag, got, 32'({rel, code}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; evt_ready = 1'b1; ovf_clr = 1'b0; keys = '0; glitch = '0;
        repeat (3) tick();
        check("rst_cols", 32'(cols), 32'h1);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_code", 32'(evt_code), 0);
        check("rst_held", 32'(key_held), 0);
        check("rst_held_code", 32'(held_code), 0);
        check("rst_multi", 32'(multi_key), 0);
        check("rst_ovf", 32'(overflow), 0);
        reset = 1'b0;

        // Press/release of key 9 (row 2, col 1) with 4-sample release debounce
        keys[9] = 1'b1;
        wait_held("a_press", 1'b1);
        check("a_held_code", 32'(held_code), 9);
        check("a_cols_locked", 32'(cols), 32'h2);
        keys[9] = 1'b0;
        repeat (5) tick();
        check("a_rel_debounce", 32'(key_held), 1);
        tick();
        check("a_rel_done", 32'(key_held), 0);
        check("a_next_col", 32'(cols), 32'h4);
        repeat (4) tick();
        expect_ev("a_ev_press", 1'b0, 4'd9);
        expect_ev("a_ev_release", 1'b1, 4'd9);

        // Two-cycle glitch on row 0 around the col 3 sample
        begin
            int n = 0;
            while (cols !== 4'b1000 && n < 100) begin tick(); n++; end
        end
        check("b_at_col3", 32'(cols), 32'h8);
        tick();
        glitch[0] = 1'b1;
        repeat (2) tick();
        glitch[0] = 1'b0;
        repeat (2) tick();
        check("b_confirm_hold", 32'(cols), 32'h8);
        tick();
        check("b_abort_col0", 32'(cols), 32'h1);
        check("b_no_hold", 32'(key_held), 0);

        // Chord on rows 0 and 3 at col 0
        keys[0] = 1'b1; keys[12] = 1'b1;
        mk_n = 0; mk_cols = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (multi_key) begin mk_n++; mk_cols = cols; end
        end
        keys[0] = 1'b0; keys[12] = 1'b0;
        check("c_multi_pulses", 32'(mk_n), 1);
        check("c_multi_col", 32'(mk_cols), 32'h2);
        check("c_no_hold", 32'(key_held), 0);
        repeat (4) tick();
        check("bc_no_events", 32'(ev_q.size()), 0);

        // Six events into a stalled 4-deep FIFO
        evt_ready = 1'b0;
        keys[5] = 1'b1;  wait_held("d_p5", 1'b1);  keys[5] = 1'b0;  wait_held("d_r5", 1'b0);
        keys[14] = 1'b1; wait_held("d_p14", 1'b1); keys[14] = 1'b0; wait_held("d_r14", 1'b0);
        keys[3] = 1'b1;  wait_held("d_p3", 1'b1);  keys[3] = 1'b0;  wait_held("d_r3", 1'b0);
        repeat (3) tick();
        check("d_ovf", 32'(overflow), 1);
        check("d_head_valid", 32'(evt_valid), 1);
        check("d_head", 32'({evt_release, evt_code}), 32'h05);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("d_ovf_clr", 32'(overflow), 0);

        // Push into the full FIFO in the same cycle as a pop
        keys[6] = 1'b1;
        wait_held("e_press", 1'b1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        repeat (2) tick();
        check("e_no_ovf", 32'(overflow), 0);
        expect_ev("e_pop0", 1'b0, 4'd5);
        evt_ready = 1'b1;
        repeat (6) tick();
        expect_ev("e_pop1", 1'b1, 4'd5);
        expect_ev("e_pop2", 1'b0, 4'd14);
        expect_ev("e_pop3", 1'b1, 4'd14);
        expect_ev("e_pop4", 1'b0, 4'd6);
        check("e_drained", 32'(ev_q.size()), 0);
        check("e_empty", 32'(evt_valid), 0);
        keys[6] = 1'b0;
        wait_held("e_release", 1'b0);
        repeat (4) tick();
        expect_ev("e_ev_rel6", 1'b1, 4'd6);

        // Asynchronous reset while a key is held and an event is queued
        evt_ready = 1'b0;
        keys[9] = 1'b1;
        wait_held("f_press", 1'b1);
        repeat (3) tick();
        check("f_pre_valid", 32'(evt_valid), 1);
        #2 reset = 1'b1;
        #1;
        check("f_cols", 32'(cols), 32'h1);
        check("f_valid", 32'(evt_valid), 0);
        check("f_held", 32'(key_held), 0);
        check("f_ovf", 32'(overflow), 0);
        check("f_code", 32'(evt_code), 0);
        keys = '0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
